// File: rtl/ball_motion_ctrl.sv
// ---------------------------------------------------------------------------
// ball_motion_ctrl
//   Ball physics and board-to-board hand-off controller for two-board pong.
//   The ball advances one step every tick period. Each step applies a
//   horizontal move, periodic gravity and floor/ceiling bounces. Paddle hits
//   on the local (left) side are accepted. When the ball reaches the right
//   column it is handed to the peer board over a valid/ready channel, or it
//   bounces locally when the design is built for a single board.
//
// Ports
//   clk_25MHZ, reset_n           clock, asynchronous active-low reset
//   game_start                   serve request (1-cycle pulse)
//   collision, hit_speed         local paddle hit and the speed level it sets
//   ball_x, ball_y, ball_vy      registered ball position / signed velocity
//   dir_right                    ball travelling right (state decode)
//   game_over, miss_count        local miss flag and saturating miss counter
//   tx_valid/tx_ready, tx_*      outgoing ball hand-off {y, vy, grav, speed}
//   rx_valid/rx_ready, rx_*      incoming ball from the peer board
// ---------------------------------------------------------------------------
module ball_motion_ctrl #(
   parameter int COORD_W     = 10,
   parameter int VEL_W       = 8,
   parameter int X_MAX       = 620,
   parameter int Y_MAX       = 239,
   parameter int X_STEP      = 10,
   parameter int TICK_BASE   = 270000,
   parameter int GRAV_PERIOD = 4,
   parameter int VY_MAX      = 15,
   parameter int SERVE_Y     = 220,
   parameter int SERVE_VY    = 3,
   parameter int TWO_BOARD   = 1
) (
   input  logic               clk_25MHZ,
   input  logic               reset_n,
   input  logic               game_start,
   input  logic               collision,
   input  logic [1:0]         hit_speed,
   output logic [COORD_W-1:0] ball_x,
   output logic [COORD_W-1:0] ball_y,
   output logic [VEL_W-1:0]   ball_vy,
   output logic               dir_right,
   output logic               game_over,
   output logic [7:0]         miss_count,
   output logic               tx_valid,
   input  logic               tx_ready,
   output logic [COORD_W-1:0] tx_y,
   output logic [VEL_W-1:0]   tx_vy,
   output logic [1:0]         tx_grav,
   output logic [1:0]         tx_speed,
   input  logic               rx_valid,
   output logic               rx_ready,
   input  logic [COORD_W-1:0] rx_y,
   input  logic [VEL_W-1:0]   rx_vy,
   input  logic [1:0]         rx_grav,
   input  logic [1:0]         rx_speed
);

   localparam int TICK_W = (TICK_BASE < 2) ? 1 : $clog2(TICK_BASE + 1);
   // Signed width for y + vy so that both overshoot directions are visible.
   localparam int YW     = COORD_W + 2;

   localparam logic [COORD_W-1:0]      X_MAX_C     = COORD_W'(X_MAX);
   localparam logic [COORD_W:0]        X_MAX_W     = (COORD_W + 1)'(X_MAX);
   localparam logic [COORD_W-1:0]      X_STEP_C    = COORD_W'(X_STEP);
   localparam logic [COORD_W:0]        X_STEP_W    = (COORD_W + 1)'(X_STEP);
   localparam logic [COORD_W-1:0]      Y_MAX_C     = COORD_W'(Y_MAX);
   localparam logic signed [YW-1:0]    Y_MAX_S     = YW'(Y_MAX);
   localparam logic signed [YW-1:0]    Y_ZERO_S    = YW'(0);
   localparam logic [COORD_W-1:0]      SERVE_Y_C   = COORD_W'(SERVE_Y);
   localparam logic signed [VEL_W-1:0] SERVE_V_C   = VEL_W'(-SERVE_VY);
   localparam logic signed [VEL_W:0]   V_ONE       = (VEL_W + 1)'(1);
   localparam logic [1:0]              GRAV_LAST   = 2'(GRAV_PERIOD - 1);
   localparam logic [TICK_W-1:0]       TICK_BASE_C = TICK_W'(TICK_BASE);
   localparam logic [TICK_W-1:0]       TICK_ONE    = TICK_W'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RUN_R,
      S_RUN_L,
      S_HANDOFF,
      S_REMOTE,
      S_OVER
   } state_t;

   // Clamp a one-bit-wider signed velocity into +/-VY_MAX.
   function automatic logic signed [VEL_W-1:0] sat_vy(input logic signed [VEL_W:0] v);
      logic signed [VEL_W:0] lim;
      logic signed [VEL_W:0] r;
      lim = (VEL_W + 1)'(VY_MAX);
      r   = v;
      if (v > lim) begin
         r = lim;
      end else if (v < -lim) begin
         r = -lim;
      end
      return r[VEL_W-1:0];
   endfunction

   state_t                  state_q, state_d;
   logic [COORD_W-1:0]      x_q, x_d;
   logic [COORD_W-1:0]      y_q, y_d;
   logic signed [VEL_W-1:0] vy_q, vy_d;
   logic [1:0]              grav_q, grav_d;
   logic [1:0]              speed_q, speed_d;
   logic [TICK_W-1:0]       tick_q, tick_d;
   logic                    tx_valid_q, tx_valid_d;
   logic                    game_over_q, game_over_d;
   logic [7:0]              miss_q, miss_d;

   logic [TICK_W-1:0]       period;
   logic                    step;
   logic                    grav_wrap;
   logic [1:0]              grav_next;
   logic signed [VEL_W:0]   vy_ext;
   logic signed [VEL_W-1:0] vy_grav;
   logic signed [VEL_W-1:0] vy_step;
   logic signed [YW-1:0]    y_sum;
   logic [COORD_W-1:0]      y_step;
   logic [COORD_W:0]        x_fwd;
   logic                    rx_ready_int;
   logic                    rx_take;
   logic                    do_serve;
   logic                    do_load;

   assign rx_ready_int = (state_q == S_REMOTE) || ((TWO_BOARD != 0) && (state_q == S_IDLE));
   assign rx_take      = rx_valid && rx_ready_int;

   // Tick period and the per-step physics candidates (used only on a step).
   always_comb begin
      period = TICK_BASE_C >> speed_q;
      // Fastest speed levels on a tiny base period still step once per clock.
      if (period == '0) begin
         period = TICK_ONE;
      end
      step      = (tick_q == (period - TICK_ONE));

      grav_wrap = (grav_q == GRAV_LAST);
      grav_next = grav_wrap ? 2'd0 : (grav_q + 2'd1);
      vy_ext    = (VEL_W + 1)'(vy_q);
      vy_grav   = grav_wrap ? sat_vy(vy_ext + V_ONE) : vy_q;

      // Position uses the velocity from before this step's gravity update.
      y_sum     = $signed({2'b00, y_q}) + YW'(vy_q);
      if (y_sum >= Y_MAX_S) begin
         y_step  = Y_MAX_C;
         vy_step = -vy_grav;
      end else if (y_sum <= Y_ZERO_S) begin
         y_step  = '0;
         vy_step = -vy_grav;
      end else begin
         y_step  = y_sum[COORD_W-1:0];
         vy_step = vy_grav;
      end

      x_fwd = {1'b0, x_q} + X_STEP_W;
   end

   // Next-state and datapath updates.
   always_comb begin
      state_d     = state_q;
      x_d         = x_q;
      y_d         = y_q;
      vy_d        = vy_q;
      grav_d      = grav_q;
      speed_d     = speed_q;
      tick_d      = tick_q;
      tx_valid_d  = tx_valid_q;
      game_over_d = game_over_q;
      miss_d      = miss_q;
      do_serve    = 1'b0;
      do_load     = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            // An incoming ball has priority over a local serve.
            if (rx_take) begin
               do_load = 1'b1;
            end else if (game_start) begin
               do_serve = 1'b1;
            end
         end
         S_RUN_R: begin
            if (step) begin
               tick_d = '0;
               grav_d = grav_next;
               vy_d   = vy_step;
               y_d    = y_step;
               if (x_fwd >= X_MAX_W) begin
                  x_d = X_MAX_C;
                  if (TWO_BOARD != 0) begin
                     state_d    = S_HANDOFF;
                     tx_valid_d = 1'b1;
                  end else begin
                     state_d = S_RUN_L;
                  end
               end else begin
                  x_d = x_fwd[COORD_W-1:0];
               end
            end else begin
               tick_d = tick_q + TICK_ONE;
            end
         end
         S_RUN_L: begin
            // A paddle hit pre-empts a step landing in the same cycle.
            if (collision) begin
               state_d = S_RUN_R;
               speed_d = hit_speed;
            end else if (step) begin
               tick_d = '0;
               grav_d = grav_next;
               vy_d   = vy_step;
               y_d    = y_step;
               if (x_q <= X_STEP_C) begin
                  x_d         = '0;
                  state_d     = S_OVER;
                  game_over_d = 1'b1;
                  if (miss_q != 8'hFF) begin
                     miss_d = miss_q + 8'd1;
                  end
               end else begin
                  x_d = x_q - X_STEP_C;
               end
            end else begin
               tick_d = tick_q + TICK_ONE;
            end
         end
         S_HANDOFF: begin
            // Payload is the frozen ball state, so it is stable until accepted.
            if (tx_valid_q && tx_ready) begin
               tx_valid_d = 1'b0;
               state_d    = S_REMOTE;
            end
         end
         S_REMOTE: begin
            if (rx_take) begin
               do_load = 1'b1;
            end
         end
         S_OVER: begin
            if (game_start) begin
               do_serve = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (do_load) begin
         state_d = S_RUN_L;
         x_d     = X_MAX_C;
         y_d     = (rx_y > Y_MAX_C) ? Y_MAX_C : rx_y;
         vy_d    = sat_vy((VEL_W + 1)'($signed(rx_vy)));
         grav_d  = rx_grav;
         speed_d = rx_speed;
      end

      if (do_serve) begin
         state_d     = S_RUN_R;
         x_d         = '0;
         y_d         = SERVE_Y_C;
         vy_d        = SERVE_V_C;
         grav_d      = 2'd0;
         speed_d     = 2'd0;
         game_over_d = 1'b0;
      end

      if (state_d != state_q) begin
         tick_d = '0;
      end
   end

   always_ff @(posedge clk_25MHZ or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         x_q         <= '0;
         y_q         <= SERVE_Y_C;
         vy_q        <= SERVE_V_C;
         grav_q      <= 2'd0;
         speed_q     <= 2'd0;
         tick_q      <= '0;
         tx_valid_q  <= 1'b0;
         game_over_q <= 1'b0;
         miss_q      <= 8'd0;
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         y_q         <= y_d;
         vy_q        <= vy_d;
         grav_q      <= grav_d;
         speed_q     <= speed_d;
         tick_q      <= tick_d;
         tx_valid_q  <= tx_valid_d;
         game_over_q <= game_over_d;
         miss_q      <= miss_d;
      end
   end

   assign ball_x     = x_q;
   assign ball_y     = y_q;
   assign ball_vy    = vy_q;
   assign dir_right  = (state_q == S_RUN_R);
   assign game_over  = game_over_q;
   assign miss_count = miss_q;
   assign tx_valid   = tx_valid_q;
   assign tx_y       = y_q;
   assign tx_vy      = vy_q;
   assign tx_grav    = grav_q;
   assign tx_speed   = speed_q;
   assign rx_ready   = rx_ready_int;

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ball_motion_ctrl
//   Self-checking bench for ball_motion_ctrl with a small game configuration.
//   A behavioural game model runs alongside the design; directed scenarios
//   are followed by randomized play.
// ---------------------------------------------------------------------------
module tb_ball_motion_ctrl;

   localparam int CW = 10;
   localparam int VW = 8;
   localparam int XM = 60;
   localparam int YM = 239;
   localparam int XS = 10;
   localparam int TB = 4;
   localparam int GP = 4;
   localparam int VM = 15;
   localparam int SY = 220;
   localparam int SV = 3;

   localparam int MD_IDLE   = 0;
   localparam int MD_RIGHT  = 1;
   localparam int MD_LEFT   = 2;
   localparam int MD_HAND   = 3;
   localparam int MD_REMOTE = 4;
   localparam int MD_OVER   = 5;

   logic          clk_25MHZ  = 1'b0;
   logic          reset_n    = 1'b0;
   logic          game_start = 1'b0;
   logic          collision  = 1'b0;
   logic [1:0]    hit_speed  = 2'd0;
   logic          tx_ready   = 1'b0;
   logic          rx_valid   = 1'b0;
   logic [CW-1:0] rx_y       = '0;
   logic [VW-1:0] rx_vy      = '0;
   logic [1:0]    rx_grav    = 2'd0;
   logic [1:0]    rx_speed   = 2'd0;

   logic [CW-1:0] ball_x;
   logic [CW-1:0] ball_y;
   logic [VW-1:0] ball_vy;
   logic          dir_right;
   logic          game_over;
   logic [7:0]    miss_count;
   logic          tx_valid;
   logic [CW-1:0] tx_y;
   logic [VW-1:0] tx_vy;
   logic [1:0]    tx_grav;
   logic [1:0]    tx_speed;
   logic          rx_ready;

   int n_checks = 0;
   int n_fail   = 0;
   int n_xfer   = 0;

   // Reference game state
   int m_mode, m_x, m_y, m_vy, m_grav, m_speed, m_tick, m_over, m_miss;

   ball_motion_ctrl #(
      .COORD_W(CW), .VEL_W(VW), .X_MAX(XM), .Y_MAX(YM), .X_STEP(XS),
      .TICK_BASE(TB), .GRAV_PERIOD(GP), .VY_MAX(VM), .SERVE_Y(SY),
      .SERVE_VY(SV), .TWO_BOARD(1)
   ) dut (
      .clk_25MHZ (clk_25MHZ),
      .reset_n   (reset_n),
      .game_start(game_start),
      .collision (collision),
      .hit_speed (hit_speed),
      .ball_x    (ball_x),
      .ball_y    (ball_y),
      .ball_vy   (ball_vy),
      .dir_right (dir_right),
      .game_over (game_over),
      .miss_count(miss_count),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .tx_y      (tx_y),
      .tx_vy     (tx_vy),
      .tx_grav   (tx_grav),
      .tx_speed  (tx_speed),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .rx_y      (rx_y),
      .rx_vy     (rx_vy),
      .rx_grav   (rx_grav),
      .rx_speed  (rx_speed)
   );

   always #20 clk_25MHZ = ~clk_25MHZ;

   always @(posedge clk_25MHZ) begin
      if (reset_n && tx_valid && tx_ready) n_xfer++;
   end

   task automatic check_eq(input string tag, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic int clamp_v(input int v);
      if (v > VM) return VM;
      if (v < -VM) return -VM;
      return v;
   endfunction

   task automatic model_reset();
      m_mode = MD_IDLE; m_x = 0; m_y = SY; m_vy = -SV;
      m_grav = 0; m_speed = 0; m_tick = 0; m_over = 0; m_miss = 0;
   endtask

   task automatic model_serve();
      m_mode = MD_RIGHT; m_x = 0; m_y = SY; m_vy = -SV;
      m_grav = 0; m_speed = 0; m_over = 0;
   endtask

   task automatic model_load();
      m_mode  = MD_LEFT;
      m_x     = XM;
      m_y     = (int'(rx_y) > YM) ? YM : int'(rx_y);
      m_vy    = clamp_v(int'($signed(rx_vy)));
      m_grav  = int'(rx_grav);
      m_speed = int'(rx_speed);
   endtask

   // One physics step for y / vy / gravity counter.
   task automatic model_phys();
      int nv, ny;
      ny = m_y + m_vy;
      nv = m_vy;
      if (m_grav == GP - 1) begin
         m_grav = 0;
         nv = clamp_v(m_vy + 1);
      end else begin
         m_grav = m_grav + 1;
      end
      if (ny >= YM) begin
         m_y = YM; m_vy = -nv;
      end else if (ny <= 0) begin
         m_y = 0; m_vy = -nv;
      end else begin
         m_y = ny; m_vy = nv;
      end
   endtask

   // Advance the model by one clock using the inputs present at the edge.
   task automatic model_step();
      int prev, per;
      prev = m_mode;
      per  = TB >> m_speed;
      if (per < 1) per = 1;
      case (m_mode)
         MD_IDLE: begin
            if (rx_valid) model_load();
            else if (game_start) model_serve();
         end
         MD_RIGHT: begin
            if (m_tick == per - 1) begin
               m_tick = 0;
               model_phys();
               if (m_x + XS >= XM) begin
                  m_x = XM; m_mode = MD_HAND;
               end else begin
                  m_x = m_x + XS;
               end
            end else begin
               m_tick++;
            end
         end
         MD_LEFT: begin
            if (collision) begin
               m_mode = MD_RIGHT; m_speed = int'(hit_speed);
            end else if (m_tick == per - 1) begin
               m_tick = 0;
               model_phys();
               if (m_x <= XS) begin
                  m_x = 0; m_mode = MD_OVER; m_over = 1;
                  if (m_miss < 255) m_miss++;
               end else begin
                  m_x = m_x - XS;
               end
            end else begin
               m_tick++;
            end
         end
         MD_HAND:   if (tx_ready) m_mode = MD_REMOTE;
         MD_REMOTE: if (rx_valid) model_load();
         MD_OVER:   if (game_start) model_serve();
         default:   m_mode = MD_IDLE;
      endcase
      if (m_mode != prev) m_tick = 0;
   endtask

   task automatic compare_all();
      check_eq("ball_x",     int'(ball_x), m_x);
      check_eq("ball_y",     int'(ball_y), m_y);
      check_eq("ball_vy",    int'($signed(ball_vy)), m_vy);
      check_eq("dir_right",  int'(dir_right), (m_mode == MD_RIGHT) ? 1 : 0);
      check_eq("game_over",  int'(game_over), m_over);
      check_eq("miss_count", int'(miss_count), m_miss);
      check_eq("tx_valid",   int'(tx_valid), (m_mode == MD_HAND) ? 1 : 0);
      check_eq("tx_y",       int'(tx_y), m_y);
      check_eq("tx_vy",      int'($signed(tx_vy)), m_vy);
      check_eq("tx_grav",    int'(tx_grav), m_grav);
      check_eq("tx_speed",   int'(tx_speed), m_speed);
      check_eq("rx_ready",   int'(rx_ready),
               (m_mode == MD_REMOTE || m_mode == MD_IDLE) ? 1 : 0);
   endtask

   task automatic cycle();
      @(posedge clk_25MHZ);
      model_step();
      #1;
      compare_all();
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   initial begin
      int k;
      model_reset();
      repeat (3) @(posedge clk_25MHZ);
      #1;
      reset_n = 1'b1;
      #1;
      compare_all();
      check_eq("rst_x",        int'(ball_x), 0);
      check_eq("rst_y",        int'(ball_y), SY);
      check_eq("rst_vy",       int'($signed(ball_vy)), -SV);
      check_eq("rst_tx_valid", int'(tx_valid), 0);
      check_eq("rst_over",     int'(game_over), 0);
      check_eq("rst_miss",     int'(miss_count), 0);
      check_eq("rst_dir",      int'(dir_right), 0);

      // Serve and first steps
      game_start = 1'b1;
      cycle();
      game_start = 1'b0;
      cycles(4);
      check_eq("serve_x1",  int'(ball_x), 10);
      check_eq("serve_y1",  int'(ball_y), 217);
      check_eq("serve_vy1", int'($signed(ball_vy)), -3);
      cycles(12);
      check_eq("serve_x4",  int'(ball_x), 40);
      check_eq("serve_y4",  int'(ball_y), 208);
      check_eq("serve_vy4", int'($signed(ball_vy)), -2);

      // Hand-off under backpressure
      tx_ready = 1'b0;
      k = 0;
      while (!tx_valid && k < 50) begin cycle(); k++; end
      check_eq("reach_handoff", int'(tx_valid), 1);
      check_eq("handoff_x", int'(ball_x), XM);
      for (int i = 0; i < 10; i++) begin
         cycle();
         check_eq("bp_valid", int'(tx_valid), 1);
         check_eq("bp_y",     int'(tx_y), 204);
         check_eq("bp_vy",    int'($signed(tx_vy)), -2);
         check_eq("bp_grav",  int'(tx_grav), 2);
         check_eq("bp_speed", int'(tx_speed), 0);
      end
      check_eq("bp_no_xfer", n_xfer, 0);
      tx_ready = 1'b1;
      cycle();
      check_eq("xfer_valid_low", int'(tx_valid), 0);
      check_eq("xfer_rx_ready",  int'(rx_ready), 1);
      cycles(2);
      check_eq("xfer_count", n_xfer, 1);
      tx_ready = 1'b0;

      // Receive with clamping
      rx_valid = 1'b1; rx_y = 10'd300; rx_vy = -8'sd20; rx_grav = 2'd0; rx_speed = 2'd2;
      cycle();
      rx_valid = 1'b0;
      check_eq("rx_y_clamp",  int'(ball_y), YM);
      check_eq("rx_vy_clamp", int'($signed(ball_vy)), -VM);
      check_eq("rx_x",        int'(ball_x), XM);
      cycle();
      check_eq("rx_x_dec1", int'(ball_x), 50);
      cycle();
      check_eq("rx_x_dec2", int'(ball_x), 40);

      // Miss on the local side, then serve again
      cycles(4);
      check_eq("miss_x",    int'(ball_x), 0);
      check_eq("miss_over", int'(game_over), 1);
      check_eq("miss_cnt",  int'(miss_count), 1);
      game_start = 1'b1;
      cycle();
      game_start = 1'b0;
      check_eq("reserve_x",    int'(ball_x), 0);
      check_eq("reserve_y",    int'(ball_y), SY);
      check_eq("reserve_dir",  int'(dir_right), 1);
      check_eq("reserve_over", int'(game_over), 0);

      // Floor bounce with gravity wrap
      tx_ready = 1'b1;
      k = 0;
      while (!rx_ready && k < 100) begin cycle(); k++; end
      check_eq("reach_remote", int'(rx_ready), 1);
      tx_ready = 1'b0;
      rx_valid = 1'b1; rx_y = 10'd235; rx_vy = 8'sd6; rx_grav = 2'd3; rx_speed = 2'd2;
      cycle();
      rx_valid = 1'b0;
      check_eq("fb_load_y", int'(ball_y), 235);
      cycle();
      check_eq("fb_y",    int'(ball_y), YM);
      check_eq("fb_vy",   int'($signed(ball_vy)), -7);
      check_eq("fb_grav", int'(tx_grav), 0);

      // Reset in the middle of a hand-off
      collision = 1'b1; hit_speed = 2'd2;
      cycle();
      collision = 1'b0;
      check_eq("hit_dir", int'(dir_right), 1);
      k = 0;
      while (!tx_valid && k < 50) begin cycle(); k++; end
      check_eq("reach_handoff2", int'(tx_valid), 1);
      #5;
      reset_n = 1'b0;
      #1;
      check_eq("async_tx_valid", int'(tx_valid), 0);
      model_reset();
      repeat (2) @(posedge clk_25MHZ);
      #1;
      reset_n = 1'b1;
      #1;
      check_eq("post_rst_idle", int'(rx_ready), 1);
      check_eq("post_rst_dir",  int'(dir_right), 0);
      check_eq("post_rst_y",    int'(ball_y), SY);
      compare_all();

      // Randomized play against the model
      for (int i = 0; i < 4000; i++) begin
         game_start = ($urandom_range(0, 15) == 0);
         collision  = ($urandom_range(0, 7) == 0);
         hit_speed  = 2'($urandom_range(0, 3));
         tx_ready   = ($urandom_range(0, 2) != 0);
         rx_valid   = ($urandom_range(0, 5) == 0);
         rx_y       = CW'($urandom_range(0, 1023));
         rx_vy      = VW'($urandom_range(0, 255));
         rx_grav    = 2'($urandom_range(0, 3));
         rx_speed   = 2'($urandom_range(0, 3));
         cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
